// File: rtl/viterbi_pkg.sv
// ---------------------------------------------------------------------------
// viterbi_pkg
// Shared definitions for the Viterbi decoder datapath.
//   - acs_state_e        : ACS bank FSM encoding (IDLE / RUN)
//   - num_states(k)      : 2^(k-1) trellis states
//   - pm_max(pm_w)       : largest representable path metric
//   - trellis_next(...)  : next state reached from state s on input bit b
//   - trellis_cw(...)    : codeword index {c0,c1} emitted on that transition
// Generator polynomials use the octal convention: K bits, MSB = newest bit.
// ---------------------------------------------------------------------------
package viterbi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } acs_state_e;

  localparam int DEF_K    = 3;
  localparam int DEF_PM_W = 6;

  function automatic int num_states(input int k);
    return 1 << (k - 1);
  endfunction

  function automatic int pm_max(input int pm_w);
    return (1 << pm_w) - 1;
  endfunction

  function automatic int trellis_next(input int s, input int b, input int k);
    return (b << (k - 2)) | (s >> 1);
  endfunction

  // Shift register contents are {b, s}; each code bit is the parity of the
  // taps selected by its generator.
  function automatic int trellis_cw(input int s, input int b, input int k,
                                    input int g0, input int g1);
    int   r;
    logic c0;
    logic c1;
    r  = (b << (k - 1)) | s;
    c0 = ^(r & g0);
    c1 = ^(r & g1);
    return 2 * int'(c0) + int'(c1);
  endfunction

endpackage

// File: rtl/acs_cell.sv
// ---------------------------------------------------------------------------
// acs_cell
// Combinational add-compare-select for one trellis state.
//   pm0_i / pm1_i : path metrics of predecessors p0 and p1
//   bm0_i / bm1_i : branch metrics of the two incoming transitions
//   npm_o         : surviving metric, saturated at 2^PM_W - 1
//   d_o           : 0 when p0 survives (also on a tie), 1 when p1 survives
// ---------------------------------------------------------------------------
module acs_cell #(
  parameter int BM_W = 2,
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [BM_W-1:0] bm0_i,
  input  logic [BM_W-1:0] bm1_i,
  output logic [PM_W-1:0] npm_o,
  output logic            d_o
);

  logic [PM_W:0]   sum0;
  logic [PM_W:0]   sum1;
  logic [PM_W-1:0] sat0;
  logic [PM_W-1:0] sat1;

  // One extra bit catches the carry so the sum clamps instead of wrapping.
  assign sum0 = {1'b0, pm0_i} + {{(PM_W + 1 - BM_W){1'b0}}, bm0_i};
  assign sum1 = {1'b0, pm1_i} + {{(PM_W + 1 - BM_W){1'b0}}, bm1_i};
  assign sat0 = sum0[PM_W] ? '1 : sum0[PM_W-1:0];
  assign sat1 = sum1[PM_W] ? '1 : sum1[PM_W-1:0];

  assign d_o   = (sat1 < sat0);
  assign npm_o = d_o ? sat1 : sat0;

endmodule

// File: rtl/acs_bank.sv
// ---------------------------------------------------------------------------
// acs_bank
// Registered add-compare-select bank: updates all 2^(K-1) path metrics in one
// step per accepted branch-metric vector.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begin a new frame (reinitialise metrics, enter RUN)
//   bm_valid, bm : branch metrics indexed by codeword {c0,c1}
//   dec_valid    : one-cycle pulse, outputs below were updated by a step
//   dec          : decision bit per next state
//   pm_out       : registered path metrics, state s at slice s
//   best_state / best_pm : minimum metric (lowest index on tie)
//   step_cnt     : steps since start, saturating
//   running      : FSM is in RUN
// Build option: define ACS_NORM_EN to subtract the minimum new metric from
// every new metric before registering.
// ---------------------------------------------------------------------------
module acs_bank
  import viterbi_pkg::*;
#(
  parameter int K    = 3,
  parameter int G0   = 7,
  parameter int G1   = 5,
  parameter int BM_W = 2,
  parameter int PM_W = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  bm_valid,
  input  logic [4*BM_W-1:0]                     bm,
  output logic                                  dec_valid,
  output logic [num_states(K)-1:0]              dec,
  output logic [num_states(K)*PM_W-1:0]         pm_out,
  output logic [K-2:0]                          best_state,
  output logic [PM_W-1:0]                       best_pm,
  output logic [15:0]                           step_cnt,
  output logic                                  running
);

  localparam int NS      = num_states(K);
  localparam int STATE_W = K - 1;
  localparam logic [PM_W-1:0] PM_MAX = PM_W'(pm_max(PM_W));

  acs_state_e          state_q;
  logic [PM_W-1:0]     pm_q [NS];
  logic [PM_W-1:0]     npm [NS];
  logic [PM_W-1:0]     pm_d [NS];
  logic [NS-1:0]       dec_d;
  logic [PM_W-1:0]     min_val;
  logic [STATE_W-1:0]  min_idx;
  logic [PM_W-1:0]     best_pm_d;
  logic                step;

  assign step = (state_q == RUN) && bm_valid;

  // Predecessors of ns share input bit b = MSB of ns; p0/p1 differ in the
  // oldest register bit that is shifted out.
  for (genvar ns = 0; ns < NS; ns++) begin : g_cell
    localparam int B   = ns >> (K - 2);
    localparam int P0  = (ns << 1) & (NS - 1);
    localparam int P1  = P0 | 1;
    localparam int CW0 = trellis_cw(P0, B, K, G0, G1);
    localparam int CW1 = trellis_cw(P1, B, K, G0, G1);

    acs_cell #(.BM_W(BM_W), .PM_W(PM_W)) u_cell (
      .pm0_i (pm_q[P0]),
      .pm1_i (pm_q[P1]),
      .bm0_i (bm[CW0*BM_W +: BM_W]),
      .bm1_i (bm[CW1*BM_W +: BM_W]),
      .npm_o (npm[ns]),
      .d_o   (dec_d[ns])
    );

    assign pm_out[ns*PM_W +: PM_W] = pm_q[ns];
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    // NOTE: defaults first so every path assigns every variable (no latches).
    min_val = npm[0];
    min_idx = '0;
    for (int s = 1; s < NS; s++) begin
      if (npm[s] < min_val) begin
        min_val = npm[s];
        min_idx = STATE_W'(s);
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NS; s++) begin
`ifdef ACS_NORM_EN
      pm_d[s] = npm[s] - min_val;
`else
      pm_d[s] = npm[s];
`endif
    end
`ifdef ACS_NORM_EN
    best_pm_d = '0;
`else
    best_pm_d = min_val;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only; the metric
  // registers are reset explicitly because the decoder relies on pm[0] = 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dec_valid  <= 1'b0;
      dec        <= '0;
      best_state <= '0;
      best_pm    <= '0;
      step_cnt   <= '0;
      for (int s = 0; s < NS; s++) pm_q[s] <= (s == 0) ? '0 : PM_MAX;
    end else if (start) begin
      // start wins over a coincident bm_valid.
      state_q    <= RUN;
      dec_valid  <= 1'b0;
      dec        <= '0;
      best_state <= '0;
      best_pm    <= '0;
      step_cnt   <= '0;
      for (int s = 0; s < NS; s++) pm_q[s] <= (s == 0) ? '0 : PM_MAX;
    end else if (step) begin
      dec_valid  <= 1'b1;
      dec        <= dec_d;
      best_state <= min_idx;
      best_pm    <= best_pm_d;
      if (step_cnt != 16'hFFFF) step_cnt <= step_cnt + 16'd1;
      for (int s = 0; s < NS; s++) pm_q[s] <= pm_d[s];
    end else begin
      dec_valid <= 1'b0;
    end
  end

  assign running = (state_q == RUN);

endmodule

// File: tb/tb_acs_bank.sv
// ---------------------------------------------------------------------------
// tb_acs_bank
// Directed bench for acs_bank with default parameters (K=3, G0=7, G1=5,
// BM_W=2, PM_W=6). bm vectors are written {bm[3],bm[2],bm[1],bm[0]};
// pm_out is written {pm3,pm2,pm1,pm0}. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_acs_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        bm_valid;
  logic [7:0]  bm;
  logic        dec_valid;
  logic [3:0]  dec;
  logic [23:0] pm_out;
  logic [1:0]  best_state;
  logic [5:0]  best_pm;
  logic [15:0] step_cnt;
  logic        running;

  int checks = 0;
  int errors = 0;

  localparam logic [23:0] PM_RESET = {6'd63, 6'd63, 6'd63, 6'd0};

  acs_bank u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bm_valid   (bm_valid),
    .bm         (bm),
    .dec_valid  (dec_valid),
    .dec        (dec),
    .pm_out     (pm_out),
    .best_state (best_state),
    .best_pm    (best_pm),
    .step_cnt   (step_cnt),
    .running    (running)
  );

  always #5 clk = ~clk;

  // Drive at negedge; the DUT captures on the next posedge and the caller
  // samples at the following negedge.
  task automatic do_step(input logic [7:0] v);
    @(negedge clk);
    bm_valid = 1'b1;
    bm       = v;
    @(negedge clk);
    bm_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bm_valid = 1'b0; bm = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (pm_out !== PM_RESET) begin errors++; $display("FAIL reset_pm: got %h expected %h", pm_out, PM_RESET); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
    checks++; if ({best_state, best_pm, step_cnt, dec} !== '0) begin errors++; $display("FAIL reset_misc: got %h expected 0", {best_state, best_pm, step_cnt, dec}); end
    // bm_valid without start is ignored in IDLE.
    do_step(8'h94);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL idle_ignore_valid: got %b expected 0", dec_valid); end
    checks++; if (pm_out !== PM_RESET) begin errors++; $display("FAIL idle_ignore_pm: got %h expected %h", pm_out, PM_RESET); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL idle_running: got %b expected 0", running); end
  endtask

  task automatic test_steps();
    do_start();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running: got %b expected 1", running); end
    // Step 1: bm = {2,1,1,0} -> pm 0,63,2,63.
    do_step(8'h94);
    checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL step1_valid: got %b expected 1", dec_valid); end
    checks++; if (pm_out !== {6'd63, 6'd2, 6'd63, 6'd0}) begin errors++; $display("FAIL step1_pm: got %h expected %h", pm_out, {6'd63, 6'd2, 6'd63, 6'd0}); end
    checks++; if (dec !== 4'b0000) begin errors++; $display("FAIL step1_dec: got %b expected 0000", dec); end
    checks++; if (best_state !== 2'd0 || best_pm !== 6'd0) begin errors++; $display("FAIL step1_best: got %0d/%0d expected 0/0", best_state, best_pm); end
    checks++; if (step_cnt !== 16'd1) begin errors++; $display("FAIL step1_cnt: got %0d expected 1", step_cnt); end
    @(negedge clk);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b expected 0", dec_valid); end
    // Step 2: same vector -> pm 0,3,2,3.
    do_step(8'h94);
    checks++; if (pm_out !== {6'd3, 6'd2, 6'd3, 6'd0}) begin errors++; $display("FAIL step2_pm: got %h expected %h", pm_out, {6'd3, 6'd2, 6'd3, 6'd0}); end
    // Step 3: bm = {0,3,0,3} -> pm 3,3,0,2; state 1 picks p1, state 0 ties to p0.
    do_step(8'h33);
    checks++; if (pm_out !== {6'd2, 6'd0, 6'd3, 6'd3}) begin errors++; $display("FAIL step3_pm: got %h expected %h", pm_out, {6'd2, 6'd0, 6'd3, 6'd3}); end
    checks++; if (dec !== 4'b0010) begin errors++; $display("FAIL step3_dec: got %b expected 0010", dec); end
    checks++; if (best_state !== 2'd2 || best_pm !== 6'd0) begin errors++; $display("FAIL step3_best: got %0d/%0d expected 2/0", best_state, best_pm); end
    checks++; if (step_cnt !== 16'd3) begin errors++; $display("FAIL step3_cnt: got %0d expected 3", step_cnt); end
  endtask

  task automatic test_all_three();
    logic [23:0] exp_pm;
    logic [5:0]  exp_best;
`ifdef ACS_NORM_EN
    exp_pm = {6'd60, 6'd0, 6'd60, 6'd0}; exp_best = 6'd0;
`else
    exp_pm = {6'd63, 6'd3, 6'd63, 6'd3}; exp_best = 6'd3;
`endif
    do_start();
    do_step(8'hFF);
    checks++; if (pm_out !== exp_pm) begin errors++; $display("FAIL all3_pm: got %h expected %h", pm_out, exp_pm); end
    checks++; if (best_state !== 2'd0 || best_pm !== exp_best) begin errors++; $display("FAIL all3_best: got %0d/%0d expected 0/%0d", best_state, best_pm, exp_best); end
  endtask

  task automatic test_saturation();
    logic [23:0] exp_62;
    logic [23:0] exp_63;
    logic [5:0]  exp_best;
`ifdef ACS_NORM_EN
    exp_62 = '0; exp_63 = '0; exp_best = 6'd0;
`else
    exp_62 = {4{6'd62}}; exp_63 = {4{6'd63}}; exp_best = 6'd63;
`endif
    do_start();
    // All bm = 2: after n >= 2 steps every metric is 2n.
    for (int i = 0; i < 31; i++) do_step(8'hAA);
    checks++; if (pm_out !== exp_62) begin errors++; $display("FAIL sat_pre_pm: got %h expected %h", pm_out, exp_62); end
    // 62 + 3 clamps to 63 on both branches: equal sums, d = 0.
    do_step(8'hFF);
    checks++; if (pm_out !== exp_63) begin errors++; $display("FAIL sat_pm: got %h expected %h", pm_out, exp_63); end
    checks++; if (dec !== 4'b0000) begin errors++; $display("FAIL sat_tie_dec: got %b expected 0000", dec); end
    checks++; if (best_state !== 2'd0 || best_pm !== exp_best) begin errors++; $display("FAIL sat_best: got %0d/%0d expected 0/%0d", best_state, best_pm, exp_best); end
    checks++; if (step_cnt !== 16'd32) begin errors++; $display("FAIL sat_cnt: got %0d expected 32", step_cnt); end
  endtask

  task automatic test_start_priority();
    @(negedge clk);
    start = 1'b1; bm_valid = 1'b1; bm = 8'h94;
    @(negedge clk);
    start = 1'b0; bm_valid = 1'b0;
    checks++; if (pm_out !== PM_RESET) begin errors++; $display("FAIL prio_pm: got %h expected %h", pm_out, PM_RESET); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL prio_valid: got %b expected 0", dec_valid); end
    checks++; if (step_cnt !== 16'd0) begin errors++; $display("FAIL prio_cnt: got %0d expected 0", step_cnt); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL prio_running: got %b expected 1", running); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bm_valid = 1'b1; bm = 8'h94;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++; if (dec_valid !== 1'b1 || step_cnt !== 16'(i)) begin errors++; $display("FAIL b2b_step%0d: got valid=%b cnt=%0d expected valid=1 cnt=%0d", i, dec_valid, step_cnt, i); end
    end
    // Assert reset between edges; outputs must clear without a clock.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (pm_out !== PM_RESET) begin errors++; $display("FAIL async_pm: got %h expected %h", pm_out, PM_RESET); end
    checks++; if ({dec_valid, running, step_cnt, dec, best_state, best_pm} !== '0) begin errors++; $display("FAIL async_misc: got %h expected 0", {dec_valid, running, step_cnt, dec, best_state, best_pm}); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dec_valid !== 1'b0 || running !== 1'b0 || step_cnt !== 16'd0) begin errors++; $display("FAIL post_rst_ignore: got valid=%b run=%b cnt=%0d expected 0/0/0", dec_valid, running, step_cnt); end
    checks++; if (pm_out !== PM_RESET) begin errors++; $display("FAIL post_rst_pm: got %h expected %h", pm_out, PM_RESET); end
    bm_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_steps();
    test_all_three();
    test_saturation();
    test_start_priority();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
